// File: rtl/latency_absorb_pkg.sv
// Shared definitions for the latency absorb buffer: counter sizing, minimum depth, error causes.
// Latency: n/a (package only).
// Backpressure: n/a.
package latency_absorb_pkg;

    localparam int MIN_DEPTH = 2;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ISSUE_NO_CREDIT,
        ERR_SPURIOUS_VALID,
        ERR_FULL_WRITE
    } err_cause_e;

    // Counters must hold the value DEPTH itself, hence depth+1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/absorb_fifo_mem.sv
// DEPTH x WIDTH storage with wrapping read/write pointers; show-ahead read port.
// Latency: write at edge t is readable from t+1; read data is combinational from rd_ptr.
// Backpressure: none here; the caller guarantees wr_en only when not full and rd_en only when not empty.
module absorb_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // DEPTH need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/latency_absorb_buffer.sv
// Absorbs a fixed-latency pipeline's output into a FIFO and grants issue credits so it can never overflow.
// Latency: pipe_valid at edge t shows out_valid from t+1; a pop at t returns its credit at t+1. Optional hwm port via LATENCY_ABSORB_HWM_EN.
// Backpressure: out_ready stalls the consumer side only; upstream is throttled through issue_ok, the pipeline never stalls.
module latency_absorb_buffer
    import latency_absorb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             err
`ifdef LATENCY_ABSORB_HWM_EN
    ,
    output logic [CNT_W-1:0] hwm
`endif
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    if (DEPTH < MIN_DEPTH) begin : g_depth_check
        $error("latency_absorb_buffer: DEPTH must be at least %0d", MIN_DEPTH);
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             issue_acc, wr_ok, pop;
    err_cause_e       cause;

    // Credit looks at registered state only, so a pop never frees a slot in the same cycle.
    assign issue_ok  = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, FULL};
    assign issue_acc = issue & issue_ok;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_ok     = pipe_valid & (inflight_q != '0) & (count_q != FULL);

    always_comb begin
        cause = ERR_NONE;
        if (issue && !issue_ok)
            cause = ERR_ISSUE_NO_CREDIT;
        else if (pipe_valid && inflight_q == '0)
            cause = ERR_SPURIOUS_VALID;
        else if (pipe_valid && count_q == FULL)
            cause = ERR_FULL_WRITE;
    end

    always_comb begin
        inflight_d = inflight_q + CNT_W'(issue_acc) - CNT_W'(wr_ok);
        count_d    = count_q + CNT_W'(wr_ok) - CNT_W'(pop);
        err_d      = err_q | (cause != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    absorb_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_data (pipe_data),
        .rd_en   (pop),
        .rd_data (out_data)
    );

    assign count = count_q;
    assign err   = err_q;

`ifdef LATENCY_ABSORB_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    assign hwm_d = (count_q > hwm_q) ? count_q : hwm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) hwm_q <= '0;
        else        hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_latency_absorb_buffer.sv
// Bench for latency_absorb_buffer: a 4-cycle delay pipeline stub feeds the DUT, a queue-based model predicts every output.
module tb_latency_absorb_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int DELAY = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue = 1'b0;
    logic             pipe_valid = 1'b0;
    logic [WIDTH-1:0] pipe_data = '0;
    logic             out_ready = 1'b0;
    logic             issue_ok, out_valid, err;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
`ifdef LATENCY_ABSORB_HWM_EN
    logic [CNT_W-1:0] hwm;
`endif

    latency_absorb_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .err        (err)
`ifdef LATENCY_ABSORB_HWM_EN
        ,
        .hwm        (hwm)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored items, items inside the pipeline, sticky error, high-water mark.
    logic [WIDTH-1:0] m_q[$];
    int               m_inflight = 0;
    bit               m_err = 1'b0;
    int               m_hwm = 0;

    // Delay pipeline stub sitting in front of the DUT.
    bit               pl_vld [DELAY];
    logic [WIDTH-1:0] pl_dat [DELAY];

    bit               use_seq = 1'b0;
    logic [WIDTH-1:0] seq = '0;
    int               n_pops = 0;
    int               max_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_credit();
        return (m_inflight + m_q.size()) < DEPTH;
    endfunction

    task automatic check_outputs();
        check_val("count", 32'(count), 32'(m_q.size()));
        check_val("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check_val("issue_ok", 32'(issue_ok), 32'(m_credit()));
        check_val("err", 32'(err), 32'(m_err));
        if (m_q.size() != 0) check_val("out_data", out_data, m_q[0]);
`ifdef LATENCY_ABSORB_HWM_EN
        check_val("hwm", 32'(hwm), 32'(m_hwm));
`endif
    endtask

    // One clock: check at negedge, drive inputs, advance model and pipeline stub, move to next negedge.
    task automatic step(input bit iss, input bit rdy, input bit spur);
        bit               pv, cred, wr_ok;
        logic [WIDTH-1:0] pd, nd;
        check_outputs();
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (out_valid && rdy) n_pops++;
        pv = pl_vld[DELAY-1];
        pd = pl_dat[DELAY-1];
        if (spur) begin
            pv = 1'b1;
            pd = WIDTH'($urandom);
        end
        issue      = iss;
        out_ready  = rdy;
        pipe_valid = pv;
        pipe_data  = pd;

        cred = m_credit();
        nd   = use_seq ? seq : WIDTH'($urandom);
        if (iss && cred) seq = seq + 1;
        for (int i = DELAY - 1; i > 0; i--) begin
            pl_vld[i] = pl_vld[i-1];
            pl_dat[i] = pl_dat[i-1];
        end
        pl_vld[0] = iss && cred;
        pl_dat[0] = nd;

        if (m_q.size() > m_hwm) m_hwm = m_q.size();
        wr_ok = pv && (m_inflight > 0) && (m_q.size() < DEPTH);
        if ((iss && !cred) || (pv && !wr_ok)) m_err = 1'b1;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (wr_ok) begin
            m_q.push_back(pd);
            m_inflight--;
        end
        if (iss && cred) m_inflight++;

        @(posedge clk);
        @(negedge clk);
    endtask

    // Pipeline stub is left untouched so items still inside it arrive after reset.
    task automatic do_reset();
        issue      = 1'b0;
        out_ready  = 1'b0;
        pipe_valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_inflight = 0;
        m_err      = 1'b0;
        m_hwm      = 0;
    endtask

    initial begin
        do_reset();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_issue_ok", 32'(issue_ok), 32'd1);
        check_val("rst_err", 32'(err), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Fill with ordered data 0..15 while the consumer is stalled.
        use_seq = 1'b1;
        seq     = '0;
        repeat (16) step(1'b1, 1'b0, 1'b0);
        check_val("credit_exhausted", 32'(issue_ok), 32'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        check_val("full_count", 32'(count), 32'd16);
        check_val("full_issue_ok", 32'(issue_ok), 32'd0);
        check_val("full_head", out_data, 32'h0);
        check_val("full_err", 32'(err), 32'd0);

        step(1'b0, 1'b1, 1'b0);
        check_val("pop_count", 32'(count), 32'd15);
        check_val("credit_return", 32'(issue_ok), 32'd1);
        check_val("second_head", out_data, 32'h1);
        repeat (16) step(1'b0, 1'b1, 1'b0);
        use_seq = 1'b0;

        // Steady state: issue on every credit, consumer always ready.
        repeat (10) step(m_credit(), 1'b1, 1'b0);
        n_pops  = 0;
        max_cnt = 0;
        repeat (50) step(m_credit(), 1'b1, 1'b0);
        check_val("throughput", 32'(n_pops), 32'd50);
        check_val("steady_count_le1", 32'(max_cnt <= 1), 32'd1);
        check_val("steady_err", 32'(err), 32'd0);
        repeat (8) step(1'b0, 1'b1, 1'b0);

        // Issue without credit.
        repeat (16) step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("noc_err", 32'(err), 32'd1);
        check_val("noc_count", 32'(count), 32'd16);
        step(1'b0, 1'b1, 1'b0);
        check_val("noc_inflight_kept", 32'(issue_ok), 32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_val("noc_err_sticky", 32'(err), 32'd1);
        do_reset();
        check_val("err_cleared", 32'(err), 32'd0);

        // pipe_valid with nothing in flight.
        step(1'b0, 1'b0, 1'b1);
        check_val("spur_err", 32'(err), 32'd1);
        check_val("spur_count", 32'(count), 32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        check_val("spur_err_sticky", 32'(err), 32'd1);
        check_val("spur_issue_ok", 32'(issue_ok), 32'd1);

        // Reset mid-stream with 7 stored and 3 in flight.
        do_reset();
        repeat (10) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("mid_count", 32'(count), 32'd7);
        do_reset();
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_issue_ok", 32'(issue_ok), 32'd1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check_val("late_valid_err", 32'(err), 32'd1);

        // Randomised traffic with a bursty consumer.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit rdy, iss;
            rdy = ($urandom % 4) != 0;
            if ((n / 50) % 2 == 1) rdy = ($urandom % 5) == 0;
            iss = (($urandom % 3) != 0) && m_credit();
            step(iss, rdy, 1'b0);
        end
        repeat (24) step(1'b0, 1'b1, 1'b0);
        check_val("rand_drained", 32'(count), 32'd0);
        check_val("rand_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
